// File: rtl/collision_detector_pkg.sv
// Shared widths, FSM encodings and the collision event layout for the collision detector.
package collision_detector_pkg;

  localparam int unsigned COLL_ADDR_WIDTH = 16;
  localparam int unsigned COLL_DATA_WIDTH = 16;

  localparam logic [0:0] ST_CLEAR  = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  typedef struct packed {
    logic [COLL_ADDR_WIDTH-1:0] index;
    logic [COLL_DATA_WIDTH-1:0] value;
  } coll_event_t;

endpackage

// File: rtl/collision_detector_if.sv
// Pixel stream from the sprite renderer and write port to the collision table.
interface collision_detector_if #(
  parameter int unsigned X_WIDTH  = 10,
  parameter int unsigned ID_WIDTH = 8
) ();
  import collision_detector_pkg::*;

  logic                       pix_valid;
  logic                       pix_ready;
  logic [X_WIDTH-1:0]         pix_x;
  logic [ID_WIDTH-1:0]        pix_sprite;
  logic                       coll_write;
  logic [COLL_ADDR_WIDTH-1:0] coll_index;
  logic [COLL_DATA_WIDTH-1:0] coll_value;

  modport master (
    output pix_valid, pix_x, pix_sprite,
    input  pix_ready, coll_write, coll_index, coll_value
  );

  modport slave (
    input  pix_valid, pix_x, pix_sprite,
    output pix_ready, coll_write, coll_index, coll_value
  );

endinterface

// File: rtl/collision_event_fifo.sv
// Synchronous event FIFO: up to two pushes and one pop per cycle, fall-through head.
module collision_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              push_cnt,
  input  logic [WIDTH-1:0]        push_d0,
  input  logic [WIDTH-1:0]        push_d1,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  free_cnt
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[wr_ptr_q] <= push_d0;
    if (push_cnt == 2'd2) mem[wr_ptr_q + PW'(1)] <= push_d1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push_cnt);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      count_q  <= count_q + (PW+1)'(push_cnt) - (PW+1)'(pop);
    end
  end

  assign head     = mem[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign free_cnt = (PW+1)'(DEPTH) - count_q;

endmodule

// File: rtl/collision_detector.sv
// Per-scanline sprite overlap detector feeding the collision table write port.
// Optional feature: define COLL_DEDUP_EN to drop repeats of the last pushed sprite pair.
module collision_detector
  import collision_detector_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = 640,
  parameter int unsigned X_WIDTH    = 10,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                line_start,
  output logic                busy,
  collision_detector_if.slave bus
);
  localparam int unsigned AW = $clog2(LINE_WIDTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [X_WIDTH-1:0] LAST_X    = X_WIDTH'(LINE_WIDTH - 1);
  localparam logic [AW-1:0]      LAST_ADDR = AW'(LINE_WIDTH - 1);

  logic [0:0]    state_q;
  logic [AW-1:0] clr_addr_q;

  // Line buffer entry layout: {valid, id}.
  logic [ID_WIDTH:0] line_mem [LINE_WIDTH];
  logic [ID_WIDTH:0] rd_data_q, fwd_data_q, entry, mem_wdata;
  logic              fwd_q, mem_we;
  logic [AW-1:0]     mem_waddr, pix_addr, s1_addr_q;

  logic                s1_valid_q, s1_in_range_q, s1_we;
  logic [ID_WIDTH-1:0] s1_id_q, stored_id;
  logic                accept, in_range, hit_raw, hit;

  coll_event_t evt_a, evt_b, out_evt, push_d0, push_d1, fifo_head, coll_q;
  logic [1:0]  push_cnt;
  logic        pop, fifo_empty, out_valid, coll_write_q;
  logic [CW-1:0] free_cnt;
  logic [CW:0]   free_after;

  always_ff @(posedge clk) begin
    if (reset || line_start) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      if (clr_addr_q == LAST_ADDR) begin
        state_q    <= ST_ACTIVE;
        clr_addr_q <= '0;
      end else begin
        clr_addr_q <= clr_addr_q + AW'(1);
      end
    end
  end

  assign pix_addr = bus.pix_x[AW-1:0];
  assign in_range = (bus.pix_x <= LAST_X);
  assign accept   = bus.pix_valid & bus.pix_ready;
  assign s1_we    = s1_valid_q & s1_in_range_q;

  assign mem_we    = (state_q == ST_CLEAR) | s1_we;
  assign mem_waddr = (state_q == ST_CLEAR) ? clr_addr_q : s1_addr_q;
  assign mem_wdata = (state_q == ST_CLEAR) ? '0 : {1'b1, s1_id_q};

  always_ff @(posedge clk) begin
    if (accept && in_range) rd_data_q <= line_mem[pix_addr];
    if (mem_we) line_mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) s1_valid_q <= 1'b0;
    else       s1_valid_q <= accept;
    if (accept) begin
      s1_addr_q     <= pix_addr;
      s1_id_q       <= bus.pix_sprite;
      s1_in_range_q <= in_range;
      // The RAM read misses the write S1 is doing this cycle; remember to use S1's data.
      fwd_q         <= s1_we && (s1_addr_q == pix_addr);
      fwd_data_q    <= {1'b1, s1_id_q};
    end
  end

  assign entry     = fwd_q ? fwd_data_q : rd_data_q;
  assign stored_id = entry[ID_WIDTH-1:0];
  assign hit_raw   = s1_we & entry[ID_WIDTH] & (stored_id != s1_id_q);

`ifdef COLL_DEDUP_EN
  logic                pair_valid_q;
  logic [ID_WIDTH-1:0] pair_lo_q, pair_hi_q, pair_lo, pair_hi;

  assign pair_lo = (s1_id_q < stored_id) ? s1_id_q : stored_id;
  assign pair_hi = (s1_id_q < stored_id) ? stored_id : s1_id_q;
  assign hit = hit_raw & ~(pair_valid_q & (pair_lo == pair_lo_q) & (pair_hi == pair_hi_q));

  always_ff @(posedge clk) begin
    if (reset || line_start) begin
      pair_valid_q <= 1'b0;
      pair_lo_q    <= '0;
      pair_hi_q    <= '0;
    end else if (hit) begin
      pair_valid_q <= 1'b1;
      pair_lo_q    <= pair_lo;
      pair_hi_q    <= pair_hi;
    end
  end
`else
  assign hit = hit_raw;
`endif

  // With the FIFO empty the first event of a pair bypasses it straight into the output register.
  always_comb begin
    evt_a.index = COLL_ADDR_WIDTH'(s1_id_q);
    evt_a.value = COLL_DATA_WIDTH'(stored_id);
    evt_b.index = COLL_ADDR_WIDTH'(stored_id);
    evt_b.value = COLL_DATA_WIDTH'(s1_id_q);
    pop       = ~fifo_empty;
    out_valid = ~fifo_empty | hit;
    out_evt   = fifo_empty ? evt_a : fifo_head;
    push_cnt  = 2'd0;
    push_d0   = evt_b;
    push_d1   = evt_b;
    if (hit && !fifo_empty) begin
      push_cnt = 2'd2;
      push_d0  = evt_a;
    end else if (hit) begin
      push_cnt = 2'd1;
    end
  end

  collision_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(coll_event_t))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_cnt (push_cnt),
    .push_d0  (push_d0),
    .push_d1  (push_d1),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .free_cnt (free_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      coll_write_q <= 1'b0;
      coll_q       <= '0;
    end else begin
      coll_write_q <= out_valid;
      if (out_valid) coll_q <= out_evt;
    end
  end

  // Space left once this cycle's pop and the in-flight pixel's pushes have landed.
  assign free_after    = {1'b0, free_cnt} + (CW+1)'(pop) - (CW+1)'(push_cnt);
  assign bus.pix_ready = (state_q == ST_ACTIVE) & ~line_start & (free_after >= (CW+1)'(2));

  assign bus.coll_write = coll_write_q;
  assign bus.coll_index = coll_q.index;
  assign bus.coll_value = coll_q.value;
  assign busy           = (state_q == ST_CLEAR) | ~fifo_empty;

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector; build with COLL_DEDUP_EN defined to cover that variant.
module tb_collision_detector;
  import collision_detector_pkg::*;

  logic clk = 1'b0;
  logic reset, line_start, busy;

  collision_detector_if #(.X_WIDTH(10), .ID_WIDTH(8)) bus ();

  collision_detector #(
    .LINE_WIDTH (640),
    .X_WIDTH    (10),
    .ID_WIDTH   (8),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int stalls = 0;
  int ev_idx[$];
  int ev_val[$];
  int ev_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.coll_write === 1'b1) begin
      ev_idx.push_back(int'(bus.coll_index));
      ev_val.push_back(int'(bus.coll_value));
      ev_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want done");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    ev_idx.delete();
    ev_val.delete();
    ev_cyc.delete();
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    @(posedge clk);
    #1;
    line_start = 1'b0;
  endtask

  task automatic count_clear(output int n);
    n = 0;
    while (bus.pix_ready !== 1'b1 && n < 2000) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pix(input int x, input int id, output int acc);
    int w;
    w = 0;
    bus.pix_valid  = 1'b1;
    bus.pix_x      = 10'(x);
    bus.pix_sprite = 8'(id);
    #1;
    while (bus.pix_ready !== 1'b1 && w < 100) begin
      w++;
      stalls++;
      @(posedge clk);
      #1;
    end
    if (w >= 100) begin
      total++;
      $display("FAIL send_pix x=%0d: pix_ready got 0 for %0d cycles want 1", x, w);
    end
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    line_start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_x = '0;
    bus.pix_sprite = '0;
    tick(3);
    total++; if (bus.pix_ready !== 1'b0) $display("FAIL reset pix_ready got %b want 0", bus.pix_ready); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL reset busy got %b want 1", busy); else passed++;
    total++; if (bus.coll_write !== 1'b0) $display("FAIL reset coll_write got %b want 0", bus.coll_write); else passed++;
    total++; if (bus.coll_index !== 16'd0) $display("FAIL reset coll_index got %0d want 0", bus.coll_index); else passed++;
    total++; if (bus.coll_value !== 16'd0) $display("FAIL reset coll_value got %0d want 0", bus.coll_value); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_clear_timing();
    int n;
    clear_events();
    pulse_line();
    count_clear(n);
    total++; if (n !== 640) $display("FAIL clear_len got %0d want 640", n); else passed++;
    total++; if (ev_idx.size() !== 0) $display("FAIL clear_no_write got %0d events want 0", ev_idx.size()); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL clear_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int a;
    clear_events();
    send_pix(10, 3, a);
    send_pix(10, 5, a);
    bus.pix_valid = 1'b0;
    tick(6);
    total++;
    if (ev_idx.size() !== 2) $display("FAIL b2b_count got %0d want 2", ev_idx.size());
    else begin
      passed++;
      total++; if (ev_idx[0] !== 5) $display("FAIL b2b_idx0 got %0d want 5", ev_idx[0]); else passed++;
      total++; if (ev_val[0] !== 3) $display("FAIL b2b_val0 got %0d want 3", ev_val[0]); else passed++;
      total++; if (ev_cyc[0] !== a + 1) $display("FAIL b2b_cyc0 got %0d want %0d", ev_cyc[0], a + 1); else passed++;
      total++; if (ev_idx[1] !== 3) $display("FAIL b2b_idx1 got %0d want 3", ev_idx[1]); else passed++;
      total++; if (ev_val[1] !== 5) $display("FAIL b2b_val1 got %0d want 5", ev_val[1]); else passed++;
      total++; if (ev_cyc[1] !== a + 2) $display("FAIL b2b_cyc1 got %0d want %0d", ev_cyc[1], a + 2); else passed++;
    end
  endtask

  task automatic test_same_id();
    int a;
    int n;
    clear_events();
    send_pix(20, 7, a);
    send_pix(20, 7, a);
    bus.pix_valid = 1'b0;
    tick(6);
    total++; if (ev_idx.size() !== 0) $display("FAIL same_id got %0d events want 0", ev_idx.size()); else passed++;
    send_pix(700, 9, a);
    send_pix(700, 8, a);
    bus.pix_valid = 1'b0;
    tick(6);
    total++; if (ev_idx.size() !== 0) $display("FAIL out_of_range got %0d events want 0", ev_idx.size()); else passed++;
    pulse_line();
    count_clear(n);
    send_pix(20, 2, a);
    send_pix(21, 2, a);
    bus.pix_valid = 1'b0;
    tick(6);
    total++; if (ev_idx.size() !== 0) $display("FAIL invalidated got %0d events want 0", ev_idx.size()); else passed++;
  endtask

  task automatic test_overlap();
    int a;
    int n;
    int exp_n;
    clear_events();
    pulse_line();
    count_clear(n);
    for (int x = 0; x < 4; x++) send_pix(x, 1, a);
    for (int x = 0; x < 4; x++) send_pix(x, 4, a);
    bus.pix_valid = 1'b0;
    tick(20);
`ifdef COLL_DEDUP_EN
    exp_n = 2;
`else
    exp_n = 8;
`endif
    total++; if (ev_idx.size() !== exp_n) $display("FAIL overlap_count got %0d want %0d", ev_idx.size(), exp_n); else passed++;
    for (int k = 0; k < exp_n && k < ev_idx.size(); k++) begin
      total++;
      if (ev_idx[k] !== ((k % 2 == 0) ? 4 : 1) || ev_val[k] !== ((k % 2 == 0) ? 1 : 4))
        $display("FAIL overlap_ev%0d got (%0d,%0d) want (%0d,%0d)", k, ev_idx[k], ev_val[k],
                 (k % 2 == 0) ? 4 : 1, (k % 2 == 0) ? 1 : 4);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int a;
    int n;
    int bad;
    clear_events();
    pulse_line();
    count_clear(n);
    for (int x = 100; x < 112; x++) send_pix(x, 1, a);
    stalls = 0;
    for (int x = 100; x < 112; x++) send_pix(x, 4, a);
    bus.pix_valid = 1'b0;
    tick(40);
`ifdef COLL_DEDUP_EN
    total++; if (ev_idx.size() !== 2) $display("FAIL bp_count got %0d want 2", ev_idx.size()); else passed++;
`else
    total++; if (ev_idx.size() !== 24) $display("FAIL bp_count got %0d want 24", ev_idx.size()); else passed++;
    total++; if (stalls == 0) $display("FAIL bp_ready_drop got %0d stall cycles want >0", stalls); else passed++;
`endif
    bad = 0;
    for (int k = 0; k < ev_idx.size(); k++)
      if (ev_idx[k] !== ((k % 2 == 0) ? 4 : 1) || ev_val[k] !== ((k % 2 == 0) ? 1 : 4)) bad++;
    total++; if (bad !== 0) $display("FAIL bp_order got %0d bad events want 0", bad); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL bp_drain busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_restart_clear();
    int n;
    pulse_line();
    tick(300);
    total++; if (bus.pix_ready !== 1'b0) $display("FAIL restart_mid got %b want 0", bus.pix_ready); else passed++;
    pulse_line();
    count_clear(n);
    total++; if (n !== 640) $display("FAIL restart_len got %0d want 640", n); else passed++;
  endtask

  task automatic test_reset_mid();
    int a;
    int n;
    int n0;
    clear_events();
    pulse_line();
    count_clear(n);
    for (int x = 200; x < 208; x++) send_pix(x, 1, a);
    for (int x = 200; x < 206; x++) send_pix(x, 6, a);
    bus.pix_valid = 1'b0;
    reset = 1'b1;
    tick(1);
    n0 = ev_idx.size();
    total++; if (bus.coll_write !== 1'b0) $display("FAIL rst_mid coll_write got %b want 0", bus.coll_write); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL rst_mid busy got %b want 1", busy); else passed++;
    total++; if (bus.pix_ready !== 1'b0) $display("FAIL rst_mid pix_ready got %b want 0", bus.pix_ready); else passed++;
    total++; if (bus.coll_index !== 16'd0) $display("FAIL rst_mid coll_index got %0d want 0", bus.coll_index); else passed++;
    reset = 1'b0;
    count_clear(n);
    total++; if (n !== 640) $display("FAIL rst_mid clear_len got %0d want 640", n); else passed++;
    total++; if (ev_idx.size() !== n0) $display("FAIL rst_mid late events got %0d want %0d", ev_idx.size(), n0); else passed++;
  endtask

  initial begin
    test_reset();
    test_clear_timing();
    test_back_to_back();
    test_same_id();
    test_overlap();
    test_backpressure();
    test_restart_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
